amm_trans_block: RTL and testbench

AMM_TRANS_BLOCK -- requirements
Module: amm_trans_block

---
 rtl/mem_checker_pkg.sv | 23 ++
 rtl/byteenable_gen.sv | 22 ++
 rtl/amm_trans_block.sv | 154 +++++++++++++++
 tb/tb_amm_trans_block.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_checker_pkg.sv
// Shared types for the memory checker: command packet and address-type constants.
// Imported by control_block and amm_trans_block.
package mem_checker_pkg;

    localparam int PKG_ADDR_W   = 8;
    localparam int PKG_BURST_W  = 11;
    localparam int PKG_OFFSET_W = 4;

    typedef enum logic {
        WORD = 1'b0,
        BYTE = 1'b1
    } addr_type_t;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0]   word_address;
        logic [PKG_BURST_W-1:0]  word_burst_count;
        logic [PKG_OFFSET_W-1:0] start_offset;
        logic [PKG_OFFSET_W-1:0] end_offset;
        logic [PKG_OFFSET_W-1:0] low_burst_bits;
        logic                    edge_aligned_addr;
    } transaction_type;

endpackage

// File: rtl/byteenable_gen.sv
// Write byteenable mask: clears bytes below start_offset on the first beat
// and bytes above end_offset on the last beat.
module byteenable_gen #(
    parameter int BYTE_PER_WORD = 16,
    parameter int BYTE_ADDR_W   = 4
) (
    input  logic [BYTE_ADDR_W-1:0]   start_offset,
    input  logic [BYTE_ADDR_W-1:0]   end_offset,
    input  logic                     first,
    input  logic                     last,
    output logic [BYTE_PER_WORD-1:0] mask
);

    always_comb begin
        mask = '1;
        for (int i = 0; i < BYTE_PER_WORD; i++) begin
            if (first && (i < int'(start_offset))) mask[i] = 1'b0;
            if (last  && (i > int'(end_offset)))   mask[i] = 1'b0;
        end
    end

endmodule

// File: rtl/amm_trans_block.sv
// Avalon-MM transaction issuer: turns one accepted command into a write burst
// or a single read request. Optional TRANS_CNT_EN adds a completed-transaction counter.
//
// state   | meaning
// IDLE_S  | ready for a command
// WRITE_S | driving write beats until the last one is taken
// READ_S  | holding the read request until it is taken
module amm_trans_block
    import mem_checker_pkg::*;
#(
    parameter int AMM_DATA_W    = 128,
    parameter int AMM_ADDR_W    = 12,
    parameter int AMM_BURST_W   = 11,
    parameter int BYTE_PER_WORD = AMM_DATA_W / 8,
    parameter int BYTE_ADDR_W   = $clog2(BYTE_PER_WORD),
    parameter int ADDR_W        = AMM_ADDR_W - BYTE_ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     op_valid_i,
    input  logic                     op_type_i,
    input  transaction_type          op_pkt_i,
    input  logic [7:0]               data_pattern_i,
    output logic                     cmd_accept_ready_o,
    output logic                     trans_block_busy_o,
    output logic [ADDR_W-1:0]        amm_address_o,
    output logic                     amm_read_o,
    output logic                     amm_write_o,
    output logic [AMM_DATA_W-1:0]    amm_writedata_o,
    output logic [BYTE_PER_WORD-1:0] amm_byteenable_o,
    output logic [AMM_BURST_W-1:0]   amm_burstcount_o,
    input  logic                     amm_waitrequest_i
`ifdef TRANS_CNT_EN
    ,
    output logic [31:0]              trans_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        WRITE_S = 2'd1,
        READ_S  = 2'd2
    } state_t;

    state_t                   state;
    logic [AMM_BURST_W-1:0]   beat_cnt;
    logic [BYTE_ADDR_W-1:0]   end_q;
    logic [AMM_BURST_W-1:0]   burst_eff;
    logic [BYTE_ADDR_W-1:0]   be_start;
    logic [BYTE_ADDR_W-1:0]   be_end;
    logic                     be_first;
    logic                     be_last;
    logic [BYTE_PER_WORD-1:0] be_mask;
    logic                     accept;
    logic                     unused_pkt;

    assign unused_pkt = ^{op_pkt_i.low_burst_bits, op_pkt_i.edge_aligned_addr};

    // A zero burstcount is issued as a single beat.
    assign burst_eff = (op_pkt_i.word_burst_count == '0) ? AMM_BURST_W'(1)
                                                         : AMM_BURST_W'(op_pkt_i.word_burst_count);
    assign accept    = (state == IDLE_S) && op_valid_i && cmd_accept_ready_o;

    // In IDLE the mask is prepared for the first beat; in WRITE it is for the beat after the current one.
    assign be_start = BYTE_ADDR_W'(op_pkt_i.start_offset);
    assign be_end   = (state == IDLE_S) ? BYTE_ADDR_W'(op_pkt_i.end_offset) : end_q;
    assign be_first = (state == IDLE_S);
    assign be_last  = (state == IDLE_S) ? (burst_eff == AMM_BURST_W'(1))
                                        : (beat_cnt == AMM_BURST_W'(2));

    byteenable_gen #(
        .BYTE_PER_WORD (BYTE_PER_WORD),
        .BYTE_ADDR_W   (BYTE_ADDR_W)
    ) u_byteenable_gen (
        .start_offset (be_start),
        .end_offset   (be_end),
        .first        (be_first),
        .last         (be_last),
        .mask         (be_mask)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state              <= IDLE_S;
            cmd_accept_ready_o <= 1'b0;
            trans_block_busy_o <= 1'b0;
            amm_read_o         <= 1'b0;
            amm_write_o        <= 1'b0;
            amm_address_o      <= '0;
            amm_burstcount_o   <= '0;
            amm_writedata_o    <= '0;
            amm_byteenable_o   <= '0;
            beat_cnt           <= '0;
            end_q              <= '0;
`ifdef TRANS_CNT_EN
            trans_cnt_o        <= '0;
`endif
        end else begin
            case (state)
                IDLE_S: begin
                    if (accept) begin
                        cmd_accept_ready_o <= 1'b0;
                        trans_block_busy_o <= 1'b1;
                        amm_address_o      <= ADDR_W'(op_pkt_i.word_address);
                        amm_burstcount_o   <= burst_eff;
                        beat_cnt           <= burst_eff;
                        end_q              <= be_end;
                        if (op_type_i) begin
                            state            <= READ_S;
                            amm_read_o       <= 1'b1;
                            amm_byteenable_o <= '1;
                        end else begin
                            state            <= WRITE_S;
                            amm_write_o      <= 1'b1;
                            amm_writedata_o  <= {BYTE_PER_WORD{data_pattern_i}};
                            amm_byteenable_o <= be_mask;
                        end
                    end else begin
                        cmd_accept_ready_o <= 1'b1;
                    end
                end
                WRITE_S: begin
                    if (!amm_waitrequest_i) begin
                        beat_cnt <= beat_cnt - AMM_BURST_W'(1);
                        if (beat_cnt == AMM_BURST_W'(1)) begin
                            state              <= IDLE_S;
                            amm_write_o        <= 1'b0;
                            trans_block_busy_o <= 1'b0;
                            cmd_accept_ready_o <= 1'b1;
`ifdef TRANS_CNT_EN
                            trans_cnt_o        <= trans_cnt_o + 32'd1;
`endif
                        end else begin
                            amm_byteenable_o <= be_mask;
                        end
                    end
                end
                READ_S: begin
                    if (!amm_waitrequest_i) begin
                        state              <= IDLE_S;
                        amm_read_o         <= 1'b0;
                        trans_block_busy_o <= 1'b0;
                        cmd_accept_ready_o <= 1'b1;
`ifdef TRANS_CNT_EN
                        trans_cnt_o        <= trans_cnt_o + 32'd1;
`endif
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end

endmodule

// File: tb/tb_amm_trans_block.sv
// Self-checking bench for amm_trans_block: a negedge monitor pops expected beats from a scoreboard.
module tb_amm_trans_block;
    import mem_checker_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic            op_valid_i = 1'b0;
    logic            op_type_i = 1'b0;
    transaction_type op_pkt_i = '0;
    logic [7:0]      data_pattern_i = 8'h00;
    logic            cmd_accept_ready_o;
    logic            trans_block_busy_o;
    logic [7:0]      amm_address_o;
    logic            amm_read_o;
    logic            amm_write_o;
    logic [127:0]    amm_writedata_o;
    logic [15:0]     amm_byteenable_o;
    logic [10:0]     amm_burstcount_o;
    logic            amm_waitrequest_i;
`ifdef TRANS_CNT_EN
    logic [31:0]     trans_cnt_o;
`endif

    logic wait_force = 1'b0;
    logic rand_wait_en = 1'b0;
    logic rand_bit = 1'b0;
    assign amm_waitrequest_i = rand_wait_en ? rand_bit : wait_force;

    int errors = 0;
    int checks = 0;
    int beats_seen = 0;

    typedef struct {
        logic         is_read;
        logic [7:0]   addr;
        logic [10:0]  burst;
        logic [127:0] data;
        logic [15:0]  be;
    } exp_t;
    exp_t exp_q[$];

    amm_trans_block dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .op_valid_i         (op_valid_i),
        .op_type_i          (op_type_i),
        .op_pkt_i           (op_pkt_i),
        .data_pattern_i     (data_pattern_i),
        .cmd_accept_ready_o (cmd_accept_ready_o),
        .trans_block_busy_o (trans_block_busy_o),
        .amm_address_o      (amm_address_o),
        .amm_read_o         (amm_read_o),
        .amm_write_o        (amm_write_o),
        .amm_writedata_o    (amm_writedata_o),
        .amm_byteenable_o   (amm_byteenable_o),
        .amm_burstcount_o   (amm_burstcount_o),
        .amm_waitrequest_i  (amm_waitrequest_i)
`ifdef TRANS_CNT_EN
        ,
        .trans_cnt_o        (trans_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        #1 rand_bit = 1'($urandom_range(0, 1));
    end

    // Monitor: every beat taken by the slave must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rst_n_i && (amm_write_o || amm_read_o) && !amm_waitrequest_i) begin
            beats_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: rd=%0b wr=%0b addr=%h be=%h, required no beat",
                         amm_read_o, amm_write_o, amm_address_o, amm_byteenable_o);
            end else begin
                exp_t e;
                logic bad;
                e = exp_q.pop_front();
                bad = (amm_read_o !== e.is_read) || (amm_write_o !== !e.is_read) ||
                      (amm_address_o !== e.addr) || (amm_burstcount_o !== e.burst) ||
                      (amm_byteenable_o !== e.be);
                if (!e.is_read && (amm_writedata_o !== e.data)) bad = 1'b1;
                if (bad) begin
                    errors++;
                    $display("FAIL beat: rd=%0b wr=%0b addr=%h burst=%0d be=%h data=%h, required rd=%0b addr=%h burst=%0d be=%h data=%h",
                             amm_read_o, amm_write_o, amm_address_o, amm_burstcount_o, amm_byteenable_o,
                             amm_writedata_o, e.is_read, e.addr, e.burst, e.be, e.data);
                end
            end
        end
    end

    function automatic logic [15:0] model_be(int b, int n, int so, int eo);
        logic [15:0] m;
        for (int i = 0; i < 16; i++)
            m[i] = ((b != 0) || (i >= so)) && ((b != n - 1) || (i <= eo));
        return m;
    endfunction

    function automatic transaction_type mk_pkt(logic [7:0] a, logic [10:0] n, logic [3:0] so, logic [3:0] eo);
        transaction_type p;
        p = '0;
        p.word_address = a;
        p.word_burst_count = n;
        p.start_offset = so;
        p.end_offset = eo;
        return p;
    endfunction

    task automatic push_beat(input logic rd, input logic [7:0] a, input logic [10:0] n,
                             input logic [7:0] pat, input logic [15:0] be);
        exp_t e;
        e.is_read = rd;
        e.addr = a;
        e.burst = n;
        e.data = {16{pat}};
        e.be = be;
        exp_q.push_back(e);
    endtask

    task automatic push_model(input logic rd, input transaction_type p, input logic [7:0] pat);
        int n;
        n = (p.word_burst_count == 0) ? 1 : int'(p.word_burst_count);
        if (rd) push_beat(1'b1, p.word_address, 11'(n), pat, 16'hFFFF);
        else
            for (int b = 0; b < n; b++)
                push_beat(1'b0, p.word_address, 11'(n), pat,
                          model_be(b, n, int'(p.start_offset), int'(p.end_offset)));
    endtask

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic send_cmd(input logic rd, input transaction_type p, input logic [7:0] pat);
        int n = 0;
        while (!cmd_accept_ready_o && n < 50) begin
            @(posedge clk_i); #1; n++;
        end
        checks++;
        if (!cmd_accept_ready_o) begin
            errors++;
            $display("FAIL ready_timeout: ready=%0b, required 1", cmd_accept_ready_o);
        end
        op_valid_i = 1'b1;
        op_type_i = rd;
        op_pkt_i = p;
        data_pattern_i = pat;
        @(posedge clk_i); #1;
        op_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (trans_block_busy_o && n < 300) begin
            @(posedge clk_i); #1; n++;
        end
        checks++;
        if (trans_block_busy_o !== 1'b0 || cmd_accept_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: busy=%0b ready=%0b, required busy=0 ready=1",
                     name, trans_block_busy_o, cmd_accept_ready_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_beats: %0d beats missing, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({cmd_accept_ready_o, trans_block_busy_o, amm_read_o, amm_write_o} !== 4'b0000 ||
            amm_address_o !== 8'h00 || amm_burstcount_o !== 11'd0 ||
            amm_byteenable_o !== 16'h0000 || amm_writedata_o !== 128'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b busy=%0b rd=%0b wr=%0b addr=%h be=%h, required all 0",
                     cmd_accept_ready_o, trans_block_busy_o, amm_read_o, amm_write_o,
                     amm_address_o, amm_byteenable_o);
        end
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (cmd_accept_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: ready=%0b, required 1", cmd_accept_ready_o);
        end
    endtask

    task automatic test_single_beat();
        int b0 = beats_seen;
        push_beat(1'b0, 8'h10, 11'd1, 8'hA5, 16'h03F8);
        send_cmd(1'b0, mk_pkt(8'h10, 11'd1, 4'd3, 4'd9), 8'hA5);
        checks++;
        if (amm_write_o !== 1'b1 || cmd_accept_ready_o !== 1'b0 || trans_block_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: wr=%0b ready=%0b busy=%0b, required 1 0 1",
                     amm_write_o, cmd_accept_ready_o, trans_block_busy_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (trans_block_busy_o !== 1'b0 || beats_seen - b0 != 1) begin
            errors++;
            $display("FAIL single_one_beat: busy=%0b beats=%0d, required 0 1",
                     trans_block_busy_o, beats_seen - b0);
        end
        wait_done("single");
    endtask

    task automatic test_burst3();
        push_beat(1'b0, 8'h33, 11'd3, 8'h5C, 16'hFFF0);
        push_beat(1'b0, 8'h33, 11'd3, 8'h5C, 16'hFFFF);
        push_beat(1'b0, 8'h33, 11'd3, 8'h5C, 16'h0003);
        send_cmd(1'b0, mk_pkt(8'h33, 11'd3, 4'd4, 4'd1), 8'h5C);
        wait_done("burst3");
    endtask

    task automatic test_read_wait();
        wait_force = 1'b1;
        push_beat(1'b1, 8'h2A, 11'd8, 8'h00, 16'hFFFF);
        send_cmd(1'b1, mk_pkt(8'h2A, 11'd8, 4'd0, 4'd15), 8'h00);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (amm_read_o !== 1'b1 || amm_address_o !== 8'h2A || amm_burstcount_o !== 11'd8 ||
                amm_byteenable_o !== 16'hFFFF || cmd_accept_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL read_hold_%0d: rd=%0b addr=%h burst=%0d be=%h ready=%0b, required 1 2a 8 ffff 0",
                         k, amm_read_o, amm_address_o, amm_burstcount_o, amm_byteenable_o, cmd_accept_ready_o);
            end
            if (k < 3) begin @(posedge clk_i); #1; end
        end
        wait_force = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (amm_read_o !== 1'b0 || cmd_accept_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL read_release: rd=%0b ready=%0b, required 0 1", amm_read_o, cmd_accept_ready_o);
        end
        wait_done("read");
    endtask

    task automatic test_burst_zero();
        int b0 = beats_seen;
        push_beat(1'b0, 8'h44, 11'd1, 8'h3C, 16'h3FFC);
        send_cmd(1'b0, mk_pkt(8'h44, 11'd0, 4'd2, 4'd13), 8'h3C);
        checks++;
        if (amm_burstcount_o !== 11'd1) begin
            errors++;
            $display("FAIL burst0_count: burstcount=%0d, required 1", amm_burstcount_o);
        end
        wait_done("burst0");
        checks++;
        if (beats_seen - b0 != 1) begin
            errors++;
            $display("FAIL burst0_beats: beats=%0d, required 1", beats_seen - b0);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        transaction_type pa, pb;
        pa = mk_pkt(8'h51, 11'd1, 4'd0, 4'd7);
        pb = mk_pkt(8'h52, 11'd2, 4'd0, 4'd0);
        push_model(1'b0, pa, 8'h11);
        push_model(1'b1, pb, 8'h22);
        op_valid_i = 1'b1; op_type_i = 1'b0; op_pkt_i = pa; data_pattern_i = 8'h11;
        @(posedge clk_i); #1;
        op_type_i = 1'b1; op_pkt_i = pb; data_pattern_i = 8'h22;
        checks++;
        if (cmd_accept_ready_o !== 1'b0 || amm_write_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_drop: ready=%0b wr=%0b, required 0 1", cmd_accept_ready_o, amm_write_o);
        end
        while (trans_block_busy_o && n < 50) begin @(posedge clk_i); #1; n++; end
        @(posedge clk_i); #1;
        op_valid_i = 1'b0;
        checks++;
        if (amm_read_o !== 1'b1 || trans_block_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: rd=%0b busy=%0b, required 1 1", amm_read_o, trans_block_busy_o);
        end
        wait_done("b2b");
    endtask

    task automatic test_reset_mid();
        push_model(1'b0, mk_pkt(8'h60, 11'd4, 4'd1, 4'd14), 8'h77);
        send_cmd(1'b0, mk_pkt(8'h60, 11'd4, 4'd1, 4'd14), 8'h77);
        @(posedge clk_i); #1;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (amm_write_o !== 1'b0 || trans_block_busy_o !== 1'b0 || cmd_accept_ready_o !== 1'b0 ||
            amm_byteenable_o !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_async: wr=%0b busy=%0b ready=%0b be=%h, required all 0",
                     amm_write_o, trans_block_busy_o, cmd_accept_ready_o, amm_byteenable_o);
        end
        checks++;
        if (exp_q.size() != 3) begin
            errors++;
            $display("FAIL rstmid_beats_left: %0d, required 3", exp_q.size());
        end
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (cmd_accept_ready_o !== 1'b1 || trans_block_busy_o !== 1'b0 || amm_write_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: ready=%0b busy=%0b wr=%0b, required 1 0 0",
                     cmd_accept_ready_o, trans_block_busy_o, amm_write_o);
        end
`ifdef TRANS_CNT_EN
        checks++;
        if (trans_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_cnt: cnt=%0d, required 0", trans_cnt_o);
        end
`endif
    endtask

    task automatic test_random_mixed();
        rand_wait_en = 1'b1;
        for (int t = 0; t < 5; t++) begin
            transaction_type p;
            logic rd;
            logic [7:0] pat;
            rd = (t == 1 || t == 3);
            pat = 8'($urandom);
            p = mk_pkt(8'($urandom), 11'($urandom_range(0, 5)), 4'($urandom), 4'($urandom));
            push_model(rd, p, pat);
            send_cmd(rd, p, pat);
            wait_done("mixed");
        end
        rand_wait_en = 1'b0;
`ifdef TRANS_CNT_EN
        checks++;
        if (trans_cnt_o !== 32'd5) begin
            errors++;
            $display("FAIL trans_cnt: cnt=%0d, required 5", trans_cnt_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst3();
        test_read_wait();
        test_burst_zero();
        test_back_to_back();
        test_reset_mid();
        test_random_mixed();
        repeat (2) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
